cgp_fitness_eval: RTL
=====================

// Module: cgp_fitness_eval
// PURPOSE
//  Serial fitness evaluator for one evolvable-circuit genotype. On start, latches the genotype.
//  Sweeps all 2**IN input vectors through a parametric ROW x COL feed-forward grid of 4-input LUT cells.
//  Compares every circuit output bit with a target truth table and reports the match count as fitness.
//  Sits between the GA engine (genotype source) and selection logic (fitness sink).
// PARAMETERS
//  IN          3    primary circuit inputs
//  OUT         2    circuit outputs
//  ROW         3    cells per column
//  COL         2    columns
//  LEVELS_BACK 1    columns behind the current column whose cells a cell input may read
//  BITS_SEL    $clog2(IN+ROW*COL)   input-mux selector width (derived, not overridable)
//  BITS_OUT    $clog2(ROW*COL)      output-mux selector width (derived)
//  FIT_W       $clog2(OUT*2**IN+1)  fitness width (derived)
// PORTS
//  clk         in   1                    system clock
//  rst         in   1                    synchronous, active-high reset
//  start       in   1                    request evaluation; accepted only when busy=0
//  saidas_LE   in   ROW*COL*16           LUT contents, cell k=c*ROW+r at [k*16+:16]
//  in_chrom    in   ROW*COL*4*BITS_SEL   input selectors, cell k at [k*4*BITS_SEL+:4*BITS_SEL], selector j at [j*BITS_SEL+:BITS_SEL]
//  out_chrom   in   OUT*BITS_OUT         output selector per circuit output
//  target      in   OUT*2**IN            expected output; bit [o*2**IN+v] = output o for input vector v
//  busy        out  1                    evaluation in progress
//  done        out  1                    one-cycle pulse, fitness valid
//  fitness     out  FIT_W                matching bits of last evaluation
//  perfect     out  1                    fitness == OUT*2**IN, valid with fitness
// BEHAVIOUR
//  Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  Reset values: busy=0, done=0, fitness=0, perfect=0. FSM returns to IDLE; the vector counter and pipeline valid bit clear.
//  FSM states and transitions:
//   - IDLE: on start, latch saidas_LE/in_chrom/out_chrom/target, set vec=0, and go to RUN.
//   - RUN: apply inp=vec to the grid and register the per-vector match count (pipeline stage 1). Then vec++.
//     When vec==2**IN-1, go to FLUSH.
//   - FLUSH: accumulate the last registered count, then go to DONE.
//   - DONE: done=1 for one cycle, then go to IDLE.
//  Accumulator clears on start acceptance. fitness and perfect update on DONE entry and hold until the next acceptance.
//  Latency: start sampled at edge 0 -> done high in cycle 2**IN+2. busy=1 from cycle 1 through the done cycle.
//  start while busy=1 is ignored (no queueing). Inputs changing mid-run have no effect; only latched copies are used.
//  Cell k (column c=k/ROW) has four inputs s0..s3. LUT output = lut[{s0,s1,s2,s3}], with s0 the address MSB.
//  Source index s for a cell selector:
//   - s<IN reads inp[s].
//   - s>=IN reads cell m=s-IN, legal only if col(m)<c and col(m)>=c-LEVELS_BACK.
//   - Any illegal or out-of-range s reads 1'b0. The grid is strictly feed-forward: no combinational loops.
//  Output o = cell[out_chrom[o]]; out_chrom[o]>=ROW*COL gives 1'b0.
//  Per-vector match = popcount(~(out ^ target column v)), OUT-bit sum. All sums unsigned, no overflow by construction of FIT_W.
//  rst mid-run aborts immediately. done never fires for the aborted run. fitness resets to 0.
//  start and rst in the same cycle: rst wins.
// STRUCTURE
//  cgp_pkg: derived widths (BITS_SEL, BITS_OUT, FIT_W), state_t enum {IDLE,RUN,FLUSH,DONE}, legal-source function.
//  Sub-module cgp_grid: purely combinational ROW x COL LUT grid plus output muxes (inp, genotype -> out).
//  This block holds the FSM, genotype latch, vector counter, pipeline register and accumulator.
// TESTING (IN=3, OUT=1, ROW=3, COL=2, LEVELS_BACK=1)
//  1. Cell0 LUT=16'h0110, s0=sel0 (inp0), s1=sel1 (inp1), s2/s3=sel all-ones (0). out_chrom=0, target=8'h66.
//     -> done in cycle 10 after start, fitness=8, perfect=1.
//  2. Same genotype, target=8'h00 -> fitness=4, perfect=0.
//  3. Pulse start again at cycles 3 and 9 of a run -> ignored. Single done at cycle 10; next run starts only after done.
//  4. Assert rst at cycle 5 of a run -> busy=0 next cycle, fitness=0, no done pulse.
//     A new start afterwards gives the correct result.
//  5. Cell0 selects cell3 (illegal forward ref), or out_chrom=7 (out of range) -> value reads 0.
//     With target=8'h00: fitness=8.
//  6. Change saidas_LE and target every cycle during the run -> fitness equals the value for the genotype latched at start.

Source files
------------

// File: rtl/cgp_pkg.sv
// Shared types and helpers for the CGP fitness evaluator.
//   state_t      : evaluator FSM states
//   bits_sel/bits_out/fit_w : derived widths from the grid geometry
//   src_legal    : whether a cell in column c may read source index s
package cgp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  function automatic int bits_sel(input int in_n, input int cells);
    return $clog2(in_n + cells);
  endfunction

  function automatic int bits_out(input int cells);
    return $clog2(cells);
  endfunction

  function automatic int fit_w(input int in_n, input int out_n);
    return $clog2(out_n * (1 << in_n) + 1);
  endfunction

  // Inputs are always readable; a cell may only read cells of the previous
  // lb columns, which keeps the grid strictly feed-forward.
  function automatic bit src_legal(input int s, input int c, input int in_n,
                                   input int row, input int col_n, input int lb);
    int m;
    int cm;
    if (s < in_n) return 1'b1;
    m = s - in_n;
    if (m >= row * col_n) return 1'b0;
    cm = m / row;
    return (cm < c) && (cm >= c - lb);
  endfunction

endpackage

// File: rtl/cgp_grid.sv
// Combinational ROW x COL grid of 4-input LUT cells plus output muxes.
//   inp       : primary input vector
//   lut       : LUT contents, cell k at [k*16+:16]
//   in_chrom  : four source selectors per cell, s0 is the LUT address MSB
//   out_chrom : cell selector per circuit output
//   out       : circuit outputs
module cgp_grid
  import cgp_pkg::*;
#(
  parameter  int IN          = 3,
  parameter  int OUT         = 2,
  parameter  int ROW         = 3,
  parameter  int COL         = 2,
  parameter  int LEVELS_BACK = 1,
  localparam int BITS_SEL    = bits_sel(IN, ROW*COL),
  localparam int BITS_OUT    = bits_out(ROW*COL)
) (
  input  logic [IN-1:0]                 inp,
  input  logic [ROW*COL*16-1:0]         lut,
  input  logic [ROW*COL*4*BITS_SEL-1:0] in_chrom,
  input  logic [OUT*BITS_OUT-1:0]       out_chrom,
  output logic [OUT-1:0]                out
);

  localparam int NCELL  = ROW * COL;
  localparam int NSRC_P = 1 << BITS_SEL;
  localparam int NOUT_P = 1 << BITS_OUT;

  // Padded to the full selector range so any out-of-range selector hits a 0.
  logic [NOUT_P-1:0] cells;

  if (NOUT_P > NCELL) begin : g_pad
    assign cells[NOUT_P-1:NCELL] = '0;
  end

  // Each column gets its own source vector built from the previous column's,
  // so no signal depends on itself and the chain stays acyclic.
  for (genvar c = 0; c < COL; c++) begin : g_col
    logic [NSRC_P-1:0] src;
    logic [NSRC_P-1:0] lmask;
    logic [NSRC_P-1:0] avail;
    logic [ROW-1:0]    cv;

    if (c == 0) begin : g_first
      assign src = NSRC_P'(inp);
    end else begin : g_next
      assign src = g_col[c-1].src | (NSRC_P'(g_col[c-1].cv) << (IN + (c-1)*ROW));
    end

    for (genvar s = 0; s < NSRC_P; s++) begin : g_mask
      assign lmask[s] = src_legal(s, c, IN, ROW, COL, LEVELS_BACK);
    end

    assign avail = src & lmask;

    for (genvar r = 0; r < ROW; r++) begin : g_row
      localparam int K = c*ROW + r;
      logic [3:0]  addr;
      logic [15:0] tbl;

      assign tbl = lut[K*16 +: 16];
      for (genvar j = 0; j < 4; j++) begin : g_sel
        assign addr[3-j] = avail[in_chrom[(K*4+j)*BITS_SEL +: BITS_SEL]];
      end
      assign cv[r]    = tbl[addr];
      assign cells[K] = cv[r];
    end
  end

  for (genvar o = 0; o < OUT; o++) begin : g_out
    assign out[o] = cells[out_chrom[o*BITS_OUT +: BITS_OUT]];
  end

endmodule

// File: rtl/cgp_fitness_eval.sv
// Serial fitness evaluator for one CGP genotype.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin evaluation (accepted only when idle)
//   saidas_LE : LUT contents per cell
//   in_chrom  : cell input selectors
//   out_chrom : output selectors
//   target    : expected truth table, bit [o*2**IN+v]
//   busy      : evaluation in progress (through the done cycle)
//   done      : one-cycle pulse when fitness/perfect are fresh
//   fitness   : number of matching output bits
//   perfect   : every output bit matched
module cgp_fitness_eval
  import cgp_pkg::*;
#(
  parameter  int IN          = 3,
  parameter  int OUT         = 2,
  parameter  int ROW         = 3,
  parameter  int COL         = 2,
  parameter  int LEVELS_BACK = 1,
  localparam int BITS_SEL    = bits_sel(IN, ROW*COL),
  localparam int BITS_OUT    = bits_out(ROW*COL),
  localparam int FIT_W       = fit_w(IN, OUT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW*COL*16-1:0]         saidas_LE,
  input  logic [ROW*COL*4*BITS_SEL-1:0] in_chrom,
  input  logic [OUT*BITS_OUT-1:0]       out_chrom,
  input  logic [OUT*(2**IN)-1:0]        target,
  output logic                          busy,
  output logic                          done,
  output logic [FIT_W-1:0]              fitness,
  output logic                          perfect
);

  localparam int NV    = 1 << IN;
  localparam int CNT_W = $clog2(OUT + 1);
  localparam logic [FIT_W-1:0] MAX_FIT = FIT_W'(OUT * NV);

  state_t state_q, state_d;

  logic [ROW*COL*16-1:0]         lat_lut;
  logic [ROW*COL*4*BITS_SEL-1:0] lat_in;
  logic [OUT*BITS_OUT-1:0]       lat_out;
  logic [OUT*NV-1:0]             lat_tgt;

  logic [IN-1:0]    vec_q;
  logic [OUT-1:0]   grid_out;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_vld;
  logic [FIT_W-1:0] acc_q;
  logic [FIT_W-1:0] acc_next;

  cgp_grid #(
    .IN(IN), .OUT(OUT), .ROW(ROW), .COL(COL), .LEVELS_BACK(LEVELS_BACK)
  ) u_grid (
    .inp       (vec_q),
    .lut       (lat_lut),
    .in_chrom  (lat_in),
    .out_chrom (lat_out),
    .out       (grid_out)
  );

  always_comb begin
    match_cnt = '0;
    for (int o = 0; o < OUT; o++)
      match_cnt = match_cnt + CNT_W'(grid_out[o] ~^ lat_tgt[o*NV + int'(vec_q)]);
  end

  assign acc_next = acc_q + FIT_W'(cnt_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (vec_q == '1) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      cnt_vld <= 1'b0;
      acc_q   <= '0;
      fitness <= '0;
      perfect <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          lat_lut <= saidas_LE;
          lat_in  <= in_chrom;
          lat_out <= out_chrom;
          lat_tgt <= target;
          vec_q   <= '0;
          acc_q   <= '0;
          cnt_vld <= 1'b0;
        end
        // Stage 1 registers this vector's count; the previous one is folded in.
        RUN: begin
          cnt_q   <= match_cnt;
          cnt_vld <= 1'b1;
          vec_q   <= vec_q + IN'(1);
          if (cnt_vld) acc_q <= acc_next;
        end
        // The last vector's count is still in the pipe; fold it and publish.
        FLUSH: begin
          cnt_vld <= 1'b0;
          acc_q   <= acc_next;
          fitness <= acc_next;
          perfect <= (acc_next == MAX_FIT);
        end
        default: ;
      endcase
    end
  end

endmodule
